// File: rtl/tt_um_taghreed_serial_add_seq.sv
// tt_um_taghreed_serial_add_seq: bit-serial 8-bit adder (A+B+cin), one full-adder cell and one carry flop, LSB first.
module tt_um_taghreed_serial_add_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t     r_state;
  logic [7:0] r_a, r_b, r_wa, r_wb, r_sum;
  logic [2:0] r_cnt;
  logic       r_c, r_cout, r_ovf;
  logic       w_load_a, w_load_b, w_start, w_cin, w_s, w_c, w_unused;
  assign w_load_a = uio_in[0];
  assign w_load_b = uio_in[1];
  assign w_start  = uio_in[2];
  assign w_cin    = uio_in[3];
  assign w_unused = ^uio_in[7:4];
  assign w_s = r_wa[0] ^ r_wb[0] ^ r_c;
  assign w_c = (r_wa[0] & r_wb[0]) | (r_wa[0] & r_c) | (r_wb[0] & r_c);
  assign uo_out  = r_sum;
  assign uio_out = {r_ovf, r_cout, r_state == DONE, r_state == ADD, 4'b0000};
  assign uio_oe  = 8'hF0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_wa    <= '0;
      r_wb    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (ena) begin
      case (r_state)
        IDLE, DONE:
          if (w_start) begin
            r_wa    <= r_a;
            r_wb    <= r_b;
            r_c     <= w_cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= ADD;
          end else begin
            if (w_load_a) r_a <= ui_in;
            if (w_load_b) r_b <= ui_in;
          end
        ADD: begin
          r_c   <= w_c;
          r_wa  <= r_wa >> 1;
          r_wb  <= r_wb >> 1;
          r_sum <= {w_s, r_sum[7:1]};
          r_cnt <= r_cnt + 3'd1;
          // on the MSB cycle r_c is the carry into bit 7 and w_c the carry out
          if (r_cnt == 3'd7) begin
            r_cout  <= w_c;
            r_ovf   <= r_c ^ w_c;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tt_um_taghreed_serial_add_seq.sv
// tb_tt_um_taghreed_serial_add_seq: scoreboard bench for the bit-serial adder.
module tb_tt_um_taghreed_serial_add_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;
  typedef struct {logic [7:0] sum; logic cout; logic ovf;} exp_t;
  exp_t       sb[$];
  logic [7:0] ma = '0, mb = '0;
  int         errs = 0, checks = 0;
  tt_um_taghreed_serial_add_seq dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [7:0] a, input logic [7:0] b);
    ui_in = a; uio_in = 8'h01;
    @(posedge clk); @(negedge clk);
    ui_in = b; uio_in = 8'h02;
    @(posedge clk); @(negedge clk);
    uio_in = 8'h00; ma = a; mb = b;
  endtask
  task automatic run(input string tag, input logic cin, input logic with_load, input int stall_at, input int stall_len);
    exp_t e;
    int   n;
    {e.cout, e.sum} = {1'b0, ma} + {1'b0, mb} + {8'd0, cin};
    e.ovf = (ma[7] == mb[7]) && (e.sum[7] != ma[7]);
    sb.push_back(e);
    ui_in = 8'h33;
    uio_in = {4'b0000, cin, 1'b1, 1'b0, with_load};
    n = 0;
    while (n < 40) begin
      @(posedge clk); n++; @(negedge clk);
      uio_in = 8'h00;
      if (uio_out[5]) break;
      if (n == stall_at) begin
        ena = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); n++; @(negedge clk);
          check({tag, "_stall_busy"}, {31'd0, uio_out[4]}, 1);
        end
        ena = 1'b1;
      end
    end
    check({tag, "_latency"}, n, 9 + stall_len);
    e = sb.pop_front();
    check({tag, "_sum"}, {24'd0, uo_out}, {24'd0, e.sum});
    check({tag, "_cout"}, {31'd0, uio_out[6]}, {31'd0, e.cout});
    check({tag, "_ovf"}, {31'd0, uio_out[7]}, {31'd0, e.ovf});
    check({tag, "_busy"}, {31'd0, uio_out[4]}, 0);
  endtask
  initial begin
    int seen;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_uo", {24'd0, uo_out}, 0);
    check("rst_uio", {24'd0, uio_out}, 0);
    check("rst_oe", {24'd0, uio_oe}, 32'hF0);
    rst_n = 1'b1;
    @(negedge clk);
    run("first", 1'b1, 1'b0, 0, 0);
    load(8'h0F, 8'h01); run("0f_01", 1'b0, 1'b0, 0, 0);
    load(8'hFF, 8'h01); run("ff_01", 1'b0, 1'b0, 0, 0);
    run("ff_01_cin", 1'b1, 1'b0, 0, 0);
    ui_in = 8'hEE; uio_in = 8'h01;
    @(posedge clk); @(negedge clk);
    uio_in = 8'h00; ma = 8'hEE;
    check("done_hold_uo", {24'd0, uo_out}, 32'h01);
    check("done_hold_done", {31'd0, uio_out[5]}, 1);
    run("ee_01", 1'b0, 1'b0, 0, 0);
    load(8'h7F, 8'h01); run("7f_01", 1'b0, 1'b0, 0, 0);
    load(8'h80, 8'h80); run("80_80", 1'b0, 1'b0, 0, 0);
    load(8'h55, 8'hAA); run("stall", 1'b1, 1'b0, 3, 5);
    load(8'h10, 8'h01); run("start_wins", 1'b0, 1'b1, 0, 0);
    run("a_kept", 1'b0, 1'b0, 0, 0);
    load(8'hFF, 8'hFF);
    uio_in = 8'h04;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      uio_in = 8'h00;
    end
    check("mid_partial_nz", {31'd0, uo_out != 8'h00}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_uo", {24'd0, uo_out}, 0);
    check("mid_rst_uio", {24'd0, uio_out}, 0);
    check("mid_rst_oe", {24'd0, uio_oe}, 32'hF0);
    #2 rst_n = 1'b1;
    ma = 8'h00; mb = 8'h00;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | {30'd0, uio_out[5:4]};
    end
    check("post_rst_idle", seen, 0);
    run("post_rst", 1'b0, 1'b0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
